// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register scoreboard of in-flight long-latency writes,
// producing the ID stall plus pending vector, stall statistics and sticky error flags.
module hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_W     = 5,
    parameter int MAX_OUTST = 3,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic                id_flush,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_writes_rd,
    input  logic                id_long_lat,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_rd,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic                stall_timeout,
    output logic                sb_underflow
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX_V = CW'(MAX_OUTST);
    localparam logic [TW-1:0] TO_V  = TW'(TIMEOUT);

    logic [CW-1:0]       r_count [NUM_REGS];
    logic [CW-1:0]       w_count_nxt [NUM_REGS];
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [TW-1:0]       r_consec;
    logic                r_timeout;
    logic                r_underflow;

    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_wb_dec;
    logic [NUM_REGS-1:0] w_issue_dec;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_waw;
    logic                w_stall;
    logic                w_issue;
    logic                w_underflow;

    // A writeback retiring the last in-flight write hides the hazard when bypassed into ID.
    always_comb begin
        w_wb_dec = '0;
        w_busy   = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            w_wb_dec[r] = wb_valid && (wb_rd == REG_W'(r));
            w_busy[r]   = (r_count[r] != '0) &&
                          !((WB_BYPASS != 0) && w_wb_dec[r] && (r_count[r] == CW'(1)));
        end
    end

    always_comb begin
        w_raw1  = id_uses_rs1 && (id_rs1 != '0) && w_busy[id_rs1];
        w_raw2  = id_uses_rs2 && (id_rs2 != '0) && w_busy[id_rs2];
        w_waw   = id_writes_rd && id_long_lat && (id_rd != '0) && (r_count[id_rd] == MAX_V);
        w_stall = id_valid && !id_flush && (w_raw1 || w_raw2 || w_waw);
        w_issue = id_valid && !id_flush && !w_stall && id_writes_rd && id_long_lat &&
                  (id_rd != '0);
    end

    // Issue and writeback to the same register in one cycle cancel out.
    always_comb begin
        w_underflow = 1'b0;
        w_issue_dec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_count_nxt[r] = r_count[r];
            if (r == 0) begin
                w_count_nxt[r] = '0;
            end else begin
                w_issue_dec[r] = w_issue && (id_rd == REG_W'(r));
                if (w_issue_dec[r] && !w_wb_dec[r]) begin
                    w_count_nxt[r] = r_count[r] + CW'(1);
                end else if (!w_issue_dec[r] && w_wb_dec[r]) begin
                    if (r_count[r] == '0) begin
                        w_underflow = 1'b1;
                    end else begin
                        w_count_nxt[r] = r_count[r] - CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_count[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_count[r] <= w_count_nxt[r];
            end
        end
    end

    // Consecutive-stall counter holds at TIMEOUT so it never wraps during a long hang.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_consec       <= '0;
            r_timeout      <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (!w_stall) begin
                r_consec <= '0;
            end else if (r_consec != TO_V) begin
                r_consec <= r_consec + TW'(1);
            end
            if ((TIMEOUT != 0) && w_stall && (r_consec == TO_V - TW'(1))) begin
                r_timeout <= 1'b1;
            end
            if (w_underflow) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pending[r] = (r_count[r] != '0);
        end
    end

    assign stall         = w_stall;
    assign stall_cycles  = r_stall_cycles;
    assign stall_timeout = r_timeout;
    assign sb_underflow  = r_underflow;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: cycle table covering RAW, WAW depth, x0, same-cycle
// issue/writeback and flush, then hand sequences for underflow, timeout and mid-run reset.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_flush, id_uses_rs1, id_uses_rs2, id_writes_rd, id_long_lat;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        wb_valid;
    logic        stall, stall_nb;
    logic [31:0] pending, pending_nb;
    logic [31:0] stall_cycles, stall_cycles_nb;
    logic        stall_timeout, stall_timeout_nb;
    logic        sb_underflow, sb_underflow_nb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_writes_rd(id_writes_rd), .id_long_lat(id_long_lat),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall), .pending(pending),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout), .sb_underflow(sb_underflow)
    );

    hazard_scoreboard #(.WB_BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_writes_rd(id_writes_rd), .id_long_lat(id_long_lat),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .stall(stall_nb), .pending(pending_nb),
        .stall_cycles(stall_cycles_nb), .stall_timeout(stall_timeout_nb),
        .sb_underflow(sb_underflow_nb)
    );

    typedef struct {
        logic        valid, flush;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        wr, lng, wbv;
        logic [4:0]  wbrd;
        logic        exp_stall, exp_stall_nb;
        logic [31:0] exp_pend;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input logic f, input logic [4:0] rs1,
                                input logic u1, input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic wr, input logic lng,
                                input logic wbv, input logic [4:0] wbrd, input logic es,
                                input logic esn, input logic [31:0] ep);
        vec_t t;
        t.valid = v;   t.flush = f;  t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd;     t.wr = wr;    t.lng = lng; t.wbv = wbv; t.wbrd = wbrd;
        t.exp_stall = es; t.exp_stall_nb = esn; t.exp_pend = ep;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.valid; id_flush = t.flush; id_rs1 = t.rs1; id_uses_rs1 = t.u1;
        id_rs2 = t.rs2; id_uses_rs2 = t.u2; id_rd = t.rd; id_writes_rd = t.wr;
        id_long_lat = t.lng; wb_valid = t.wbv; wb_rd = t.wbrd;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic reset_and_check(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, " pending"}, 64'(pending), 64'd0);
        chk({nm, " stall_cycles"}, 64'(stall_cycles), 64'd0);
        chk({nm, " stall_timeout"}, 64'(stall_timeout), 64'd0);
        chk({nm, " sb_underflow"}, 64'(sb_underflow), 64'd0);
        chk({nm, " stall"}, 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_sc;
        // cycle table: load-use on x5, x0 writes/reads, WAW depth on x7,
        // same-cycle issue/wb on x9, flushed hazarded reader of x3
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 32'h20);
        tbl[1]  = mk(1, 0, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 1, 32'h20);
        tbl[2]  = mk(1, 0, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 1, 32'h20);
        tbl[3]  = mk(1, 0, 5, 1, 1, 1, 6, 1, 0, 1, 5, 0, 1, 32'h0);
        tbl[4]  = mk(1, 0, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 32'h0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0);
        tbl[6]  = mk(1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 32'h0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 32'h80);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 32'h80);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 32'h80);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 1, 32'h80);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 1, 7, 1, 1, 32'h80);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 32'h80);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h80);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h80);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 32'h0);
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 32'h200);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 9, 1, 1, 1, 9, 0, 0, 32'h200);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 32'h8);
        tbl[20] = mk(1, 1, 3, 1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 32'h8);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 32'h0);

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset pending", 64'(pending), 64'd0);
        chk("reset stall_cycles", 64'(stall_cycles), 64'd0);
        chk("reset flags", 64'({stall_timeout, sb_underflow}), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        exp_sc = 0;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d stall", i), 64'(stall), 64'(tbl[i].exp_stall));
            chk($sformatf("vec%0d stall_nobypass", i), 64'(stall_nb), 64'(tbl[i].exp_stall_nb));
            if (tbl[i].exp_stall) exp_sc++;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d pending", i), 64'(pending), 64'(tbl[i].exp_pend));
            @(negedge clk);
        end
        chk("table stall_cycles", 64'(stall_cycles), 64'(exp_sc));
        chk("table sb_underflow", 64'(sb_underflow), 64'd0);

        // writeback to x0 is ignored; writeback to idle x4 raises sticky underflow
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("wb x0 no underflow", 64'(sb_underflow), 64'd0);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("wb x4 underflow", 64'(sb_underflow), 64'd1);
        chk("wb x4 pending", 64'(pending), 64'd0);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        chk("underflow sticky", 64'(sb_underflow), 64'd1);

        reset_and_check("rst1");

        // load x12 then a reader of x12 held without writeback
        drive(mk(1, 0, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        drive(mk(1, 0, 12, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk);
            #1;
            if (k == 1023) begin
                chk("timeout before 1024", 64'(stall_timeout), 64'd0);
                chk("stall_cycles at 1023", 64'(stall_cycles), 64'd1023);
            end
            @(negedge clk);
        end
        chk("timeout at 1024", 64'(stall_timeout), 64'd1);
        chk("stall_cycles at 1024", 64'(stall_cycles), 64'd1024);
        chk("still stalled", 64'(stall), 64'd1);
        chk("pending x12", 64'(pending), 64'h1000);

        reset_and_check("rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
